vid_text_fetch: RTL and testbench

VID_TEXT_FETCH -- requirements
Module: vid_text_fetch

---
 rtl/vid_pkg.sv | 44 ++++
 rtl/vid_line_buf.sv | 24 ++
 rtl/vid_text_fetch.sv | 193 +++++++++++++++++++
 tb/tb_vid_text_fetch.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// Shared constants, types and the pixel-pick helper for the text-mode
// line fetcher.
package vid_pkg;

  localparam int SCR_W    = 48;
  localparam int SCR_H    = 28;
  localparam int CHAR_W   = 8;
  localparam int CHAR_H   = 16;
  localparam int SCR_LAT  = 3;
  localparam int FONT_LAT = 2;

  localparam int X_W       = $clog2(SCR_W);
  localparam int Y_W       = $clog2(SCR_H);
  localparam int ROW_W     = $clog2(CHAR_H);
  localparam int COL_W     = $clog2(CHAR_W);
  localparam int ISSUE_CYC = 2 * SCR_W;
  localparam int LINE_PIX  = SCR_W * CHAR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic           vld;
    logic           sel;
    logic [X_W-1:0] x;
  } scr_tag_t;

  typedef struct packed {
    logic           vld;
    logic [X_W-1:0] x;
    logic [3:0]     attr;
  } fnt_tag_t;

  // Entry layout is {glyph[7:0], attr[3:0]}; glyph bit 7 is the leftmost pixel.
  function automatic logic [3:0] pix_pick(input logic [11:0] ent, input logic [COL_W-1:0] col);
    logic [7:0] glyph;
    glyph = ent[11:4];
    return glyph[3'd7 - col] ? ent[3:0] : 4'h0;
  endfunction

endpackage

// File: rtl/vid_line_buf.sv
// Two banks of one text line each; one write port, one registered read port.
module vid_line_buf
  import vid_pkg::*;
(
  input  logic           clk,
  input  logic           we_i,
  input  logic           wbank_i,
  input  logic [X_W-1:0] waddr_i,
  input  logic [11:0]    wdata_i,
  input  logic           rbank_i,
  input  logic [X_W-1:0] raddr_i,
  output logic [11:0]    rdata_o
);

  logic [11:0] mem_q [2][SCR_W];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[wbank_i][waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[rbank_i][raddr_i];
  end

endmodule

// File: rtl/vid_text_fetch.sv
// Text-mode line fetcher: screen RAM -> font RAM -> double-buffered line,
// then serialises one 384-pixel line on demand.
module vid_text_fetch
  import vid_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ln_start,
  input  logic [8:0]       ln_y,
  output logic [X_W-1:0]   vp_x_0,
  output logic [Y_W-1:0]   vp_y_0,
  output logic             vp_sel_0,
  input  logic [7:0]       vp_data_3,
  output logic [11:0]      fn_addr_0,
  input  logic [7:0]       fn_data_2,
  input  logic             pix_start,
  output logic             pix_valid,
  output logic [3:0]       pix_color,
  output logic             fetch_busy,
  output logic             underrun
);

  fetch_state_e     state_q, state_d;
  logic [6:0]       cnt_q, cnt_d;
  logic [8:0]       y_q;
  scr_tag_t         scr_q [SCR_LAT];
  scr_tag_t         scr_in_s;
  fnt_tag_t         fnt_q [FONT_LAT];
  logic             char_ret_s, we_s, done_s, fill_s, swap_s;
  logic [1:0]       val_q, val_d;
  logic             disp_q, disp_d, und_q, und_d;
  logic             run_q, run_d, blank_q, blank_d;
  logic [8:0]       pcnt_q, pcnt_d;
  logic             pv_q, pbk_q;
  logic [COL_W-1:0] pcol_q;
  logic [11:0]      rdata_s;

  assign char_ret_s = scr_q[SCR_LAT-1].vld && !scr_q[SCR_LAT-1].sel;
  assign we_s       = fnt_q[FONT_LAT-1].vld && !ln_start;
  assign done_s     = we_s && (fnt_q[FONT_LAT-1].x == X_W'(SCR_W - 1));
  assign fill_s     = ~disp_q;
  assign swap_s     = pix_start && val_q[fill_s];

  assign vp_y_0     = y_q[8:4];
  assign fn_addr_0  = char_ret_s ? {vp_data_3, y_q[ROW_W-1:0]} : 12'd0;
  assign fetch_busy = (state_q != ST_IDLE);
  assign underrun   = und_q;
  assign pix_valid  = pv_q;
  assign pix_color  = (pv_q && !pbk_q) ? pix_pick(rdata_s, pcol_q) : 4'h0;

  always_comb begin
    vp_x_0   = '0;
    vp_sel_0 = 1'b0;
    scr_in_s = '0;
    if (state_q == ST_ISSUE) begin
      vp_x_0   = cnt_q[6:1];
      vp_sel_0 = cnt_q[0];
      scr_in_s = {1'b1, cnt_q[0], cnt_q[6:1]};
    end else begin
      vp_x_0   = '0;
      vp_sel_0 = 1'b0;
      scr_in_s = '0;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (ln_start) begin
      state_d = ST_ISSUE;
      cnt_d   = 7'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          cnt_d   = 7'd0;
        end
        ST_ISSUE: begin
          if (cnt_q == 7'(ISSUE_CYC - 1)) begin
            state_d = ST_DRAIN;
            cnt_d   = 7'd0;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
        ST_DRAIN: begin
          if (done_s) begin
            state_d = ST_IDLE;
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 7'd0;
        end
      endcase
    end
  end

  // Buffer ownership: a swap happens before a same-cycle ln_start picks its fill bank.
  always_comb begin
    val_d   = val_q;
    disp_d  = disp_q;
    und_d   = und_q;
    run_d   = run_q;
    pcnt_d  = pcnt_q;
    blank_d = blank_q;
    if (pix_start) begin
      run_d   = 1'b1;
      pcnt_d  = 9'd0;
      blank_d = !swap_s;
      if (swap_s) begin
        disp_d        = fill_s;
        val_d[fill_s] = 1'b0;
      end else begin
        und_d = 1'b1;
      end
    end else if (run_q) begin
      if (pcnt_q == 9'(LINE_PIX - 1)) begin
        run_d = 1'b0;
      end else begin
        pcnt_d = pcnt_q + 9'd1;
      end
    end else begin
      run_d = 1'b0;
    end
    if (ln_start) begin
      val_d[~disp_d] = 1'b0;
    end else begin
      val_d[fill_s] = val_d[fill_s] | done_s;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 7'd0;
      y_q     <= 9'd0;
      val_q   <= 2'b00;
      disp_q  <= 1'b0;
      und_q   <= 1'b0;
      run_q   <= 1'b0;
      pcnt_q  <= 9'd0;
      blank_q <= 1'b0;
      pv_q    <= 1'b0;
      pbk_q   <= 1'b0;
      pcol_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= ln_start ? ln_y : y_q;
      val_q   <= val_d;
      disp_q  <= disp_d;
      und_q   <= und_d;
      run_q   <= run_d;
      pcnt_q  <= pcnt_d;
      blank_q <= blank_d;
      pv_q    <= run_q;
      pbk_q   <= blank_q;
      pcol_q  <= pcnt_q[COL_W-1:0];
    end
  end

  // Return tags: the attribute nibble joins its char tag one cycle after the char
  // returns, so it lines up with the glyph row from the font RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SCR_LAT; i++) scr_q[i] <= '0;
      for (int i = 0; i < FONT_LAT; i++) fnt_q[i] <= '0;
    end else if (ln_start) begin
      for (int i = 0; i < SCR_LAT; i++) scr_q[i] <= '0;
      for (int i = 0; i < FONT_LAT; i++) fnt_q[i] <= '0;
    end else begin
      scr_q[0] <= scr_in_s;
      for (int i = 1; i < SCR_LAT; i++) scr_q[i] <= scr_q[i-1];
      fnt_q[0] <= {char_ret_s, scr_q[SCR_LAT-1].x, 4'h0};
      fnt_q[FONT_LAT-1] <= {fnt_q[0].vld, fnt_q[0].x, vp_data_3[3:0]};
    end
  end

  vid_line_buf u_line_buf (
    .clk     (clk),
    .we_i    (we_s),
    .wbank_i (fill_s),
    .waddr_i (fnt_q[FONT_LAT-1].x),
    .wdata_i ({fn_data_2, fnt_q[FONT_LAT-1].attr}),
    .rbank_i (disp_q),
    .raddr_i (pcnt_q[8:3]),
    .rdata_o (rdata_s)
  );

endmodule

// File: tb/tb_vid_text_fetch.sv
// Directed bench for vid_text_fetch with screen/font RAM response models.
module tb_vid_text_fetch;

  logic        clk;
  logic        rst_n;
  logic        ln_start;
  logic [8:0]  ln_y;
  logic [5:0]  vp_x_0;
  logic [4:0]  vp_y_0;
  logic        vp_sel_0;
  logic [7:0]  vp_data_3;
  logic [11:0] fn_addr_0;
  logic [7:0]  fn_data_2;
  logic        pix_start;
  logic        pix_valid;
  logic [3:0]  pix_color;
  logic        fetch_busy;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;

  vid_text_fetch dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ln_start   (ln_start),
    .ln_y       (ln_y),
    .vp_x_0     (vp_x_0),
    .vp_y_0     (vp_y_0),
    .vp_sel_0   (vp_sel_0),
    .vp_data_3  (vp_data_3),
    .fn_addr_0  (fn_addr_0),
    .fn_data_2  (fn_data_2),
    .pix_start  (pix_start),
    .pix_valid  (pix_valid),
    .pix_color  (pix_color),
    .fetch_busy (fetch_busy),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] glyph_of(input logic [7:0] ch, input logic [3:0] row);
    return ch ^ {row, row} ^ 8'hFE;
  endfunction

  // Screen RAM: char(x)=x+0x20, attr=x%16 with junk in the upper nibble; 3-cycle latency.
  logic [6:0] sa1, sa2, sa3;
  always @(posedge clk) begin
    sa1 <= {vp_sel_0, vp_x_0};
    sa2 <= sa1;
    sa3 <= sa2;
  end
  assign vp_data_3 = sa3[6] ? {4'h5, sa3[3:0]} : (8'(sa3[5:0]) + 8'h20);

  logic [11:0] fa1, fa2;
  always @(posedge clk) begin
    fa1 <= fn_addr_0;
    fa2 <= fa1;
  end
  assign fn_data_2 = glyph_of(fa2[11:4], fa2[3:0]);

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic ls, input logic ps, input logic [8:0] y);
    ln_start  = ls;
    pix_start = ps;
    ln_y      = y;
    step();
    ln_start  = 1'b0;
    pix_start = 1'b0;
  endtask

  // Called on the first ISSUE cycle; returns on the first IDLE cycle.
  task automatic fetch_check(input logic [8:0] y);
    check_val("vp_y", 32'(vp_y_0), 32'(y[8:4]));
    check_val("busy_issue", 32'(fetch_busy), 32'd1);
    for (int i = 0; i < 96; i++) begin
      check_val("vp_x", 32'(vp_x_0), 32'(i / 2));
      check_val("vp_sel", 32'(vp_sel_0), 32'(i % 2));
      if (i < 3) check_val("fn_addr_quiet", 32'(fn_addr_0), 32'd0);
      else if (i == 3) check_val("fn_addr_first", 32'(fn_addr_0), 32'({8'h20, y[3:0]}));
      step();
    end
    check_val("vp_x_drain", 32'(vp_x_0), 32'd0);
    step();
    step();
    step();
    check_val("busy_drain", 32'(fetch_busy), 32'd1);
    step();
    check_val("busy_done", 32'(fetch_busy), 32'd0);
    check_val("vp_x_idle", 32'(vp_x_0), 32'd0);
    check_val("vp_sel_idle", 32'(vp_sel_0), 32'd0);
    check_val("fn_addr_idle", 32'(fn_addr_0), 32'd0);
    check_val("vp_y_hold", 32'(vp_y_0), 32'(y[8:4]));
  endtask

  // Called one cycle after pix_start.
  task automatic check_line(input logic [8:0] y, input logic blank);
    logic [7:0] g;
    logic [3:0] ex;
    check_val("pix_lat", 32'(pix_valid), 32'd0);
    for (int p = 0; p < 384; p++) begin
      step();
      g  = glyph_of(8'(p / 8) + 8'h20, y[3:0]);
      ex = (blank || !g[3'(7 - (p % 8))]) ? 4'h0 : 4'((p / 8) % 16);
      check_val("pix", 32'({pix_valid, pix_color}), 32'({1'b1, ex}));
    end
    step();
    check_val("pix_end", 32'({pix_valid, pix_color}), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    ln_start  = 1'b0;
    pix_start = 1'b0;
    ln_y      = 9'd0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_vp_x", 32'(vp_x_0), 32'd0);
    check_val("rst_vp_y", 32'(vp_y_0), 32'd0);
    check_val("rst_fn_addr", 32'(fn_addr_0), 32'd0);
    check_val("rst_pix", 32'({pix_valid, pix_color}), 32'd0);
    check_val("rst_busy", 32'(fetch_busy), 32'd0);
    check_val("rst_underrun", 32'(underrun), 32'd0);
    rst_n = 1'b1;
    step();

    // No completed line yet: blank output and sticky underrun.
    pulse(1'b0, 1'b1, 9'd0);
    check_line(9'd0, 1'b1);
    check_val("underrun_set", 32'(underrun), 32'd1);

    // Normal fetch of row 37 (vp_y 2, glyph row 5) and its display.
    pulse(1'b1, 1'b0, 9'd37);
    fetch_check(9'd37);
    pulse(1'b0, 1'b1, 9'd0);
    check_line(9'd37, 1'b0);
    check_val("underrun_sticky1", 32'(underrun), 32'd1);

    // Abort at ISSUE cycle 40 and restart with row 100.
    pulse(1'b1, 1'b0, 9'd37);
    repeat (40) step();
    check_val("abort_pre_x", 32'(vp_x_0), 32'd20);
    pulse(1'b1, 1'b0, 9'd100);
    fetch_check(9'd100);

    // Swap and new fill in the same cycle; fill runs while the line is shown.
    pulse(1'b1, 1'b1, 9'd200);
    check_line(9'd100, 1'b0);
    check_val("busy_after_overlap", 32'(fetch_busy), 32'd0);
    pulse(1'b0, 1'b1, 9'd0);
    check_line(9'd200, 1'b0);

    // Line already shown: nothing new to swap in.
    pulse(1'b0, 1'b1, 9'd0);
    check_line(9'd0, 1'b1);
    check_val("underrun_sticky2", 32'(underrun), 32'd1);

    // Reset mid-output and mid-ISSUE.
    pulse(1'b0, 1'b1, 9'd0);
    pulse(1'b1, 1'b0, 9'd37);
    repeat (20) step();
    check_val("pre_rst_x", 32'(vp_x_0), 32'd10);
    check_val("pre_rst_valid", 32'(pix_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_val("arst_vp_x", 32'(vp_x_0), 32'd0);
    check_val("arst_vp_y", 32'(vp_y_0), 32'd0);
    check_val("arst_pix", 32'({pix_valid, pix_color}), 32'd0);
    check_val("arst_busy", 32'(fetch_busy), 32'd0);
    check_val("arst_underrun", 32'(underrun), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    pulse(1'b1, 1'b0, 9'd37);
    fetch_check(9'd37);
    pulse(1'b0, 1'b1, 9'd0);
    check_line(9'd37, 1'b0);
    check_val("underrun_clear", 32'(underrun), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
